jt1942_prog_sdram: RTL and testbench

JT1942_PROG_SDRAM -- requirements
Module: jt1942_prog_sdram

---
 rtl/jt1942_prog_sdram.sv | 113 +++++++++++
 tb/tb_jt1942_prog_sdram.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jt1942_prog_sdram.sv
// Buffers PROM/ROM download writes in a small FIFO and feeds them to the SDRAM
// controller one request at a time. It also reports dropped writes, counts
// acknowledged writes and pulses done once the download has fully drained.
module jt1942_prog_sdram #(
  parameter int AW = 22,
  parameter int QW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          downloading,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [7:0]    prog_data,
  input  logic [1:0]    prog_mask,
  output logic          sdram_req,
  output logic [AW-1:0] sdram_addr,
  output logic [15:0]   sdram_din,
  output logic [1:0]    sdram_dqm,
  input  logic          sdram_ack,
  output logic          overflow,
  output logic [AW-1:0] wr_cnt,
  output logic          done,
  output logic          dbg_state
);

  // Handshake: sdram_req stays high with addr/din/dqm frozen until the
  // controller raises sdram_ack; the edge that samples req & ack retires the entry.
  localparam int DEPTH = 1 << QW;
  localparam logic [QW:0] FULL_CNT = (QW+1)'(DEPTH);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t        state, state_next;
  logic          load;
  logic [AW-1:0] fifo_addr [DEPTH];
  logic [7:0]    fifo_data [DEPTH];
  logic [1:0]    fifo_mask [DEPTH];
  logic [QW-1:0] rd_ptr, wr_ptr;
  logic [QW:0]   count;
  logic          dl_q, push_seen;
  logic          push_req, push, pop, drop, full, empty, dl_rise, done_cond;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign pop       = (state == REQ) && sdram_ack;
  assign push_req  = prog_we && downloading;
  // A full FIFO still takes a write if the head retires on the same edge.
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;
  assign dl_rise   = downloading && !dl_q;
  assign done_cond = !downloading && empty && (state == IDLE) && push_seen;
  assign dbg_state = state;

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        state_next = REQ;
        load       = 1'b1;
      end
      REQ: if (sdram_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= prog_addr;
      fifo_data[wr_ptr] <= prog_data;
      fifo_mask[wr_ptr] <= prog_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      sdram_din  <= '0;
      sdram_dqm  <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      wr_cnt     <= '0;
      done       <= 1'b0;
      dl_q       <= 1'b0;
      push_seen  <= 1'b0;
    end else begin
      state     <= state_next;
      sdram_req <= (state_next == REQ);
      if (load) begin
        sdram_addr <= fifo_addr[rd_ptr];
        sdram_din  <= {fifo_data[rd_ptr], fifo_data[rd_ptr]};
        sdram_dqm  <= fifo_mask[rd_ptr];
      end
      if (push) wr_ptr <= wr_ptr + QW'(1);
      if (pop)  rd_ptr <= rd_ptr + QW'(1);
      if (push && !pop)      count <= count + (QW+1)'(1);
      else if (!push && pop) count <= count - (QW+1)'(1);
      dl_q <= downloading;
      done <= done_cond;
      if (push)                        push_seen <= 1'b1;
      else if (dl_rise || done_cond)   push_seen <= 1'b0;
      if (drop)         overflow <= 1'b1;
      else if (dl_rise) overflow <= 1'b0;
      if (dl_rise)      wr_cnt <= '0;
      else if (pop)     wr_cnt <= wr_cnt + AW'(1);
    end
  end

endmodule

// File: tb/tb_jt1942_prog_sdram.sv
// Directed bench for jt1942_prog_sdram: stimulus queues expected SDRAM writes,
// a negedge monitor retires them whenever the DUT's request is acknowledged.
module tb_jt1942_prog_sdram;
  localparam int AW = 22;
  localparam int W  = AW + 18;

  logic          clk, rst, downloading, prog_we, sdram_ack;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_data;
  logic [1:0]    prog_mask;
  logic          sdram_req, overflow, done, dbg_state;
  logic [AW-1:0] sdram_addr, wr_cnt;
  logic [15:0]   sdram_din;
  logic [1:0]    sdram_dqm;

  jt1942_prog_sdram #(.AW(AW), .QW(2)) dut (
    .clk(clk), .rst(rst), .downloading(downloading), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_din(sdram_din),
    .sdram_dqm(sdram_dqm), .sdram_ack(sdram_ack), .overflow(overflow),
    .wr_cnt(wr_cnt), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          done_cnt = 0;
  int          d0;
  logic        done_prev = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && sdram_req && sdram_ack) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got %0h expected none", {sdram_addr, sdram_din, sdram_dqm});
      end else begin
        e = exp_q.pop_front();
        check("write", 64'({sdram_addr, sdram_din, sdram_dqm}), 64'(e));
      end
    end
    if (done) begin
      done_cnt++;
      check("done_width", 64'(done_prev), 64'(0));
    end
    done_prev = done;
  end

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [7:0] d, input logic [1:0] m,
                         input bit accept);
    prog_addr = a;
    prog_data = d;
    prog_mask = m;
    prog_we   = 1'b1;
    if (accept) exp_q.push_back({a, d, d, m});
    tick();
    prog_we = 1'b0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 40 && !sdram_req; i++) tick();
    check("req_timeout", 64'(sdram_req), 64'(1));
  endtask

  task automatic ack_one(input int gap);
    wait_req();
    repeat (gap) tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; downloading = 1'b0; prog_we = 1'b0; sdram_ack = 1'b0;
    prog_addr = '0; prog_data = '0; prog_mask = '0;
    repeat (3) tick();
    check("rst_req", 64'(sdram_req), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    check("rst_wrcnt", 64'(wr_cnt), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_addr", 64'(sdram_addr), 64'(0));
    check("rst_din", 64'(sdram_din), 64'(0));
    check("rst_dqm", 64'(sdram_dqm), 64'(0));
    rst = 1'b0;
    tick();

    // single write, latency and payload
    downloading = 1'b1;
    tick();
    push_wr(22'h0A000, 8'h5A, 2'b10, 1);
    check("lat_n", 64'(sdram_req), 64'(0));
    tick();
    check("lat_n1", 64'(sdram_req), 64'(1));
    check("t1_addr", 64'(sdram_addr), 64'h0A000);
    check("t1_din", 64'(sdram_din), 64'h5A5A);
    check("t1_dqm", 64'(sdram_dqm), 64'(2));
    repeat (2) tick();
    check("req_hold", 64'(sdram_req), 64'(1));
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    check("req_after_ack", 64'(sdram_req), 64'(0));
    check("t1_wrcnt", 64'(wr_cnt), 64'(1));
    tick();
    check("idle_gap", 64'(sdram_req), 64'(0));

    // burst overflow in a fresh download
    d0 = done_cnt;
    downloading = 1'b0;
    repeat (3) tick();
    check("done_t1", 64'(done_cnt), 64'(d0 + 1));
    downloading = 1'b1;
    tick();
    check("wrcnt_clear", 64'(wr_cnt), 64'(0));
    for (int i = 0; i < 6; i++)
      push_wr(AW'(32'h100 + i), 8'(8'h10 + i), 2'(i), i < 4);
    check("ovf_set", 64'(overflow), 64'(1));
    check("ovf_req", 64'(sdram_req), 64'(1));
    repeat (4) ack_one(1);
    check("t2_wrcnt", 64'(wr_cnt), 64'(4));
    repeat (3) tick();
    check("t2_idle", 64'(sdram_req), 64'(0));
    check("t2_empty", 64'(exp_q.size()), 64'(0));

    // full FIFO with push and pop on one edge
    d0 = done_cnt;
    downloading = 1'b0;
    repeat (3) tick();
    check("done_t2", 64'(done_cnt), 64'(d0 + 1));
    downloading = 1'b1;
    tick();
    check("ovf_clear", 64'(overflow), 64'(0));
    for (int i = 0; i < 4; i++)
      push_wr(AW'(32'h200 + i), 8'(8'hA0 + i), 2'b01, 1);
    wait_req();
    prog_addr = 22'h204; prog_data = 8'hA4; prog_mask = 2'b11;
    prog_we = 1'b1; sdram_ack = 1'b1;
    exp_q.push_back({22'h204, 8'hA4, 8'hA4, 2'b11});
    tick();
    prog_we = 1'b0; sdram_ack = 1'b0;
    check("full_pp_ovf", 64'(overflow), 64'(0));
    repeat (4) ack_one(0);
    check("t3_wrcnt", 64'(wr_cnt), 64'(5));
    check("t3_ovf", 64'(overflow), 64'(0));
    repeat (3) tick();
    check("t3_idle", 64'(sdram_req), 64'(0));
    check("t3_empty", 64'(exp_q.size()), 64'(0));

    // drain after download ends
    d0 = done_cnt;
    downloading = 1'b0;
    repeat (3) tick();
    check("done_t3", 64'(done_cnt), 64'(d0 + 1));
    downloading = 1'b1;
    tick();
    d0 = done_cnt;
    for (int i = 0; i < 3; i++)
      push_wr(AW'(32'h300 + i), 8'(8'hC0 + i), 2'b00, 1);
    downloading = 1'b0;
    ack_one(1);
    ack_one(1);
    wait_req();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    check("done_not_yet", 64'(done), 64'(0));
    check("no_early_done", 64'(done_cnt), 64'(d0));
    tick();
    check("done_pulse", 64'(done), 64'(1));
    tick();
    check("done_one_cycle", 64'(done), 64'(0));
    repeat (4) tick();
    check("done_once", 64'(done_cnt), 64'(d0 + 1));

    // reset during a request, then a stale ack
    downloading = 1'b1;
    tick();
    d0 = done_cnt;
    push_wr(22'h3FFFFF, 8'hEE, 2'b00, 1);
    wait_req();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("rst_mid_req", 64'(sdram_req), 64'(0));
    check("rst_mid_wrcnt", 64'(wr_cnt), 64'(0));
    sdram_ack = 1'b1;
    repeat (2) tick();
    sdram_ack = 1'b0;
    check("stale_ack_req", 64'(sdram_req), 64'(0));
    check("stale_ack_wrcnt", 64'(wr_cnt), 64'(0));
    downloading = 1'b0;
    push_wr(22'h123, 8'h11, 2'b00, 0);
    repeat (5) tick();
    check("ignore_we", 64'(sdram_req), 64'(0));
    check("no_done_after_rst", 64'(done_cnt), 64'(d0));

    // restart clears overflow/wr_cnt; done needs a new push
    downloading = 1'b1;
    tick();
    for (int i = 0; i < 6; i++)
      push_wr(AW'(32'h400 + i), 8'(8'h30 + i), 2'b10, i < 4);
    check("t6_ovf", 64'(overflow), 64'(1));
    repeat (4) ack_one(0);
    check("t6_wrcnt", 64'(wr_cnt), 64'(4));
    d0 = done_cnt;
    downloading = 1'b0;
    repeat (3) tick();
    check("done_t6", 64'(done_cnt), 64'(d0 + 1));
    downloading = 1'b1;
    tick();
    check("restart_ovf", 64'(overflow), 64'(0));
    check("restart_wrcnt", 64'(wr_cnt), 64'(0));
    d0 = done_cnt;
    downloading = 1'b0;
    repeat (5) tick();
    check("no_done_empty", 64'(done_cnt), 64'(d0));
    downloading = 1'b1;
    tick();
    push_wr(22'h500, 8'h77, 2'b01, 1);
    downloading = 1'b0;
    ack_one(0);
    repeat (3) tick();
    check("done_rearm", 64'(done_cnt), 64'(d0 + 1));
    check("rearm_wrcnt", 64'(wr_cnt), 64'(1));
    check("final_empty", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
